// File: rtl/mult_ctrl_pkg.sv
// Shared types for the multiplier-sharing controller: FSM states and counter width.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wide enough for any MULT_LAT up to 15.
    localparam int CNT_W = 4;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester and response bus of the shared multiplier; clients drive master, controller is slave.
interface mult_share_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_y;

    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(rr_ptr) + i) % N_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one registered multiplier between N_REQ requesters with round-robin
// arbitration and returns id-tagged products over a valid/ready port.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 1,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    mult_share_ctrl_if.slave   bus,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               mult_en,
    input  logic [2*WIDTH-1:0] mult_y,
    output logic               busy
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  win_grant;
    logic [ID_W-1:0]   win_idx;
    logic              win_any;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .grant  (win_grant),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        sel_a = bus.a_in[int'(win_idx)*WIDTH +: WIDTH];
        sel_b = bus.b_in[int'(win_idx)*WIDTH +: WIDTH];
    end

    // All outputs are registered; gnt defaults low so it can only pulse on the IDLE exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            mult_a        <= '0;
            mult_b        <= '0;
            mult_en       <= 1'b0;
            busy          <= 1'b0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_y     <= '0;
        end else begin
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        mult_a     <= sel_a;
                        mult_b     <= sel_b;
                        bus.gnt    <= win_grant;
                        bus.rsp_id <= win_idx;
                        rr_ptr     <= ID_W'(wrap_inc(int'(win_idx), N_REQ));
                        cnt        <= CNT_W'(MULT_LAT);
                        mult_en    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bus.rsp_y     <= mult_y;
                        bus.rsp_valid <= 1'b1;
                        mult_en       <= 1'b0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: protocol-level model checked every cycle
// plus directed scenarios with hand-computed products and grant orders.
module tb_mult_share_ctrl;

    localparam int MULT_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_en;
    logic [15:0] mult_y = 16'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mult_share_ctrl_if #(.N_REQ(4), .WIDTH(8), .ID_W(2)) bus ();

    mult_share_ctrl #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MULT_LAT (MULT_LAT),
        .ID_W     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mult_a  (mult_a),
        .mult_b  (mult_b),
        .mult_en (mult_en),
        .mult_y  (mult_y),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for reg_mult16: one register stage, holds when en is low.
    always @(posedge clk) begin
        if (mult_en) mult_y <= {8'd0, mult_a} * {8'd0, mult_b};
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Model state: what the controller must be doing, derived from the protocol rules.
    bit          m_idle  = 1'b1;
    int          m_ptr   = 0;
    int          m_wait  = 0;
    bit          m_valid = 1'b0;
    bit          hs_prev = 1'b0;
    logic [3:0]  req_prev = 4'd0;
    logic [31:0] a_prev = 32'd0;
    logic [31:0] b_prev = 32'd0;
    int          exp_ma = 0;
    int          exp_mb = 0;
    int          sb_id[$];
    int          sb_y[$];
    int          grant_log[$];
    logic [7:0]  prev_ma = 8'd0;
    logic [7:0]  prev_mb = 8'd0;
    logic        prev_en = 1'b0;

    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        int w;
        if (rst) begin
            m_idle = 1'b1; m_ptr = 0; m_wait = 0; m_valid = 1'b0; hs_prev = 1'b0;
            req_prev = 4'd0; prev_en = 1'b0;
            sb_id.delete(); sb_y.delete();
        end else begin
            exp_gnt = 4'd0;
            w = 0;
            if (m_idle) begin
                if (req_prev != 4'd0) begin
                    w = pick(req_prev, m_ptr);
                    exp_gnt = 4'(1 << w);
                end
            end else if (hs_prev) begin
                m_idle = 1'b1;
                m_valid = 1'b0;
                if (sb_id.size() > 0) begin
                    void'(sb_id.pop_front());
                    void'(sb_y.pop_front());
                end
            end
            check_output("gnt", int'(bus.gnt), int'(exp_gnt));
            assert ($onehot0(bus.gnt)) else $error("[TB] gnt not one-hot");
            if (exp_gnt != 4'd0) begin
                exp_ma = int'(a_prev[w*8 +: 8]);
                exp_mb = int'(b_prev[w*8 +: 8]);
                sb_id.push_back(w);
                sb_y.push_back(exp_ma * exp_mb);
                grant_log.push_back(w);
                m_ptr  = (w + 1) % 4;
                m_idle = 1'b0;
                m_wait = MULT_LAT + 1;
            end else if (!m_idle && m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end
            check_output("busy", int'(busy), int'(!m_idle));
            check_output("rsp_valid", int'(bus.rsp_valid), int'(m_valid));
            check_output("mult_en", int'(mult_en), int'(!m_idle && !m_valid));
            if (!m_idle && !m_valid) begin
                check_output("mult_a", int'(mult_a), exp_ma);
                check_output("mult_b", int'(mult_b), exp_mb);
            end
            if (prev_en && mult_en) begin
                assert (mult_a == prev_ma && mult_b == prev_mb) else $error("[TB] operands moved under en");
            end
            if (m_valid && sb_id.size() > 0) begin
                check_output("rsp_id", int'(bus.rsp_id), sb_id[0]);
                check_output("rsp_y", int'(bus.rsp_y), sb_y[0]);
            end
            hs_prev  = m_valid && bus.rsp_ready;
            req_prev = bus.req;
            a_prev   = bus.a_in;
            b_prev   = bus.b_in;
            prev_en  = mult_en;
            prev_ma  = mult_a;
            prev_mb  = mult_b;
        end
    end

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.a_in[i*8 +: 8] = a;
        bus.b_in[i*8 +: 8] = b;
    endtask

    task automatic apply_stimulus(input logic [3:0] r);
        bus.req = r;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        int c = 0;
        g = 4'd0;
        while (c < 100 && g == 4'd0) begin
            @(posedge clk); #2;
            c++;
            g = bus.gnt;
        end
        if (g == 4'd0) check_output("gnt_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
        if (!bus.rsp_valid) check_output("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 200) begin
            @(posedge clk); #2;
            c++;
        end
        if (busy) check_output("idle_timeout", 0, 1);
    endtask

    task automatic run_grants(input int n, input bit drop);
        int seen = 0;
        int c = 0;
        while (seen < n && c < 400) begin
            @(posedge clk); #2;
            c++;
            if (|bus.gnt) begin
                seen++;
                if (drop) bus.req = bus.req & ~bus.gnt;
            end
        end
        if (seen < n) check_output("grant_timeout", seen, n);
        bus.req = 4'd0;
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_gnt"}, int'(bus.gnt), 0);
        check_output({tag, "_mult_a"}, int'(mult_a), 0);
        check_output({tag, "_mult_b"}, int'(mult_b), 0);
        check_output({tag, "_mult_en"}, int'(mult_en), 0);
        check_output({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        check_output({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
        check_output({tag, "_rsp_y"}, int'(bus.rsp_y), 0);
        check_output({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] g;
        int lat;
        int rr_order[5];
        rr_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        bus.req = 4'd0;
        bus.a_in = 32'd0;
        bus.b_in = 32'd0;
        bus.rsp_ready = 1'b1;

        check_output("model_pick_wrap", pick(4'b0011, 3), 0);
        check_output("model_pick_mid", pick(4'b1111, 2), 2);

        repeat (2) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #2;

        // Single request: 12 * 45 = 540.
        set_ops(0, 8'd12, 8'd45);
        apply_stimulus(4'b0001);
        wait_gnt(g);
        check_output("single_gnt", int'(g), 1);
        bus.req = bus.req & ~g;
        wait_valid(lat);
        check_output("single_latency", lat, MULT_LAT + 1);
        check_output("single_rsp_y", int'(bus.rsp_y), 540);
        check_output("single_rsp_id", int'(bus.rsp_id), 0);
        wait_idle();

        // Full-scale operands: 255 * 255 = 65025.
        set_ops(3, 8'd255, 8'd255);
        apply_stimulus(4'b1000);
        wait_gnt(g);
        check_output("max_gnt", int'(g), 8);
        bus.req = bus.req & ~g;
        wait_valid(lat);
        check_output("max_rsp_y", int'(bus.rsp_y), 65025);
        check_output("max_rsp_id", int'(bus.rsp_id), 3);
        wait_idle();

        // All four requesting continuously: 0,1,2,3 then back to 0.
        set_ops(0, 8'd3, 8'd4);
        set_ops(1, 8'd10, 8'd20);
        set_ops(2, 8'd100, 8'd200);
        set_ops(3, 8'd250, 8'd2);
        grant_log.delete();
        apply_stimulus(4'b1111);
        run_grants(5, 1'b0);
        check_output("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check_output($sformatf("rr_order%0d", i), grant_log[i], rr_order[i]);
        end

        // Stalled consumer: response must hold and nothing new is granted.
        bus.rsp_ready = 1'b0;
        set_ops(2, 8'd7, 8'd9);
        apply_stimulus(4'b0100);
        wait_gnt(g);
        check_output("bp_gnt", int'(g), 4);
        bus.req = 4'b1011;
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check_output("bp_valid", int'(bus.rsp_valid), 1);
            check_output("bp_rsp_y", int'(bus.rsp_y), 63);
            check_output("bp_rsp_id", int'(bus.rsp_id), 2);
            check_output("bp_no_gnt", int'(bus.gnt), 0);
            @(posedge clk); #2;
        end
        bus.rsp_ready = 1'b1;
        bus.req = 4'd0;
        wait_idle();

        // Pointer sits at 3; requests 0 and 1 must wrap to 0 first.
        grant_log.delete();
        apply_stimulus(4'b0011);
        run_grants(2, 1'b1);
        check_output("wrap_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_output("wrap_first", grant_log[0], 0);
            check_output("wrap_second", grant_log[1], 1);
        end

        // Reset while the multiplier is in flight: the op is dropped.
        set_ops(1, 8'd3, 8'd5);
        apply_stimulus(4'b0010);
        wait_gnt(g);
        check_output("rst_gnt", int'(g), 2);
        bus.req = 4'd0;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            check_output("postrst_valid", int'(bus.rsp_valid), 0);
            check_output("postrst_busy", int'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
